data_pro_seq: RTL and testbench
===============================

Name: data_pro_seq

Overview:
- Parametrised successor of the team's fixed 4-bit pre-increment/multiply datapath.
- Each operand is offset by a constant, then multiplied by an iterative shift-add engine.
- Presents the product plus a sign-magnitude-to-two's-complement view.
- valid/ready handshakes on both sides; sits between the operand source and the result consumer in the data processing chain.

Parameters:
- W, 4, operand width in bits; product width is 2*W.
- INC, 1, constant added to each operand before multiplication, modulo 2^W.

Ports:
- clk  input  1  clock, rising edge.
- res  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- data_in_a  input  W  operand A, unsigned.
- data_in_b  input  W  operand B, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- data_out  output  2*W  registered product (accumulated sum when DATA_PRO_ACC_EN is defined).
- data_out_comp  output  2*W  combinational conversion of data_out.
- busy  output  1  high in MUL state.
- inc_wrap  output  1  registered flag: the pre-increment of A or B wrapped on the last accepted pair.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low, ports named clk and res.
- Reset (res low, immediate, no clock needed):
  - state=IDLE.
  - data_out=0, out_valid=0, inc_wrap=0, busy=0, in_ready=1 once state is IDLE.
  - Multiplier registers and counter cleared.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On the edge with in_valid&in_ready:
    - Capture opA=(data_in_a+INC) mod 2^W and opB=(data_in_b+INC) mod 2^W.
    - inc_wrap = carry-out of either addition.
    - Clear the partial product, load counter=W, go to MUL.
- MUL:
  - in_ready=0, busy=1.
  - Each edge: if LSB of the multiplier shift register is 1, add the shifted multiplicand to the partial product (2*W bits, no overflow possible); shift; decrement counter.
  - On the edge where the counter reaches 0: write the product to data_out, set out_valid=1, go to DONE.
  - Latency: out_valid first high immediately after the W-th clock edge following the accepting edge.
- DONE:
  - out_valid=1, in_ready=0.
  - data_out and inc_wrap are held stable while out_ready=0 (unbounded stall).
  - On the edge with out_ready=1: out_valid=0, go to IDLE. data_out retains its value.
- in_valid while in_ready=0 is ignored; no operand queueing; the source must hold until the handshake.
- Throughput: one result per W+2 cycles minimum, given out_ready held high.
- data_out_comp:
  - if data_out[2W-1]=1: {1'b1, (~data_out[2W-2:0]+1) mod 2^(2W-1)}.
  - else: equal to data_out.
  - Special case: 1 followed by all zeros maps to itself.
- Reset asserted mid-MUL or mid-DONE: transaction discarded, all outputs return to reset values at once; no result is emitted after release.
- Operand wrap case: data_in = 2^W-1 with INC=1 yields operand 0, product 0, inc_wrap=1.

Optional Feature:
- Macro: DATA_PRO_ACC_EN.
- Defined:
  - Adds input acc_clr (1 bit) and output acc_ovf (1 bit).
  - On entering DONE: data_out <= (data_out + product) mod 2^(2W).
  - acc_ovf is sticky-set on carry-out of that addition.
  - acc_clr high on a clock edge while in IDLE zeros data_out and acc_ovf; ignored in other states.
  - Reset clears both.
- Not defined:
  - acc_clr and acc_ovf ports are absent.
  - data_out = product of the current transaction only.

Test Plan (W=4, INC=1):
1. Basic product and latency:
   - Stimulus: a=2, b=3, out_ready=1.
   - Required: operands 3 and 4; data_out=0x0C, data_out_comp=0x0C, inc_wrap=0.
   - Required timing: out_valid high after the 4th edge following accept; next in_ready one cycle later.
2. MSB-set product:
   - Stimulus: a=14, b=14.
   - Required: 15*15, data_out=0xE1, data_out_comp=0x9F.
3. Operand wrap:
   - Stimulus: a=15, b=5.
   - Required: opA=0, data_out=0x00, inc_wrap=1.
   - Stimulus: follow with a=0, b=0.
   - Required: data_out=0x01, inc_wrap=0.
4. Output stall:
   - Stimulus: result of scenario 2 ready; hold out_ready=0 for 10 cycles while pulsing in_valid with a=1, b=1.
   - Required: out_valid, data_out=0xE1 and in_ready=0 stable throughout; the pulsed input is never captured.
   - Stimulus: out_ready=1.
   - Required: out_valid drops on the next edge.
5. Reset mid-operation:
   - Stimulus: res low for one cycle, 2 edges into MUL.
   - Required: data_out=0, out_valid=0, busy=0 immediately; no out_valid after release; in_ready=1.
6. Accumulate (DATA_PRO_ACC_EN defined):
   - Stimulus: pairs (2,3), (14,14), (2,3), (14,14).
   - Required: data_out = 0x0C, 0xED, 0xF9, 0xDA; acc_ovf=1 after the fourth pair.
   - Stimulus: acc_clr in IDLE.
   - Required: data_out=0, acc_ovf=0.

Source files
------------

// File: rtl/data_pro_seq.sv
// Offset-then-multiply datapath: operands get +INC (mod 2^W) and go through a W-cycle shift-add multiplier.
// Optional build macro DATA_PRO_ACC_EN turns data_out into a running accumulator with acc_clr/acc_ovf.
module data_pro_seq #(
    parameter int W   = 4,
    parameter int INC = 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     data_in_a,
    input  logic [W-1:0]     data_in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   data_out,
    output logic [2*W-1:0]   data_out_comp,
    output logic             busy,
    output logic             inc_wrap
`ifdef DATA_PRO_ACC_EN
    ,
    input  logic             acc_clr,
    output logic             acc_ovf
`endif
);

    localparam int PW = 2 * W;
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] INC_V = W'(INC);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t state, state_next;

    logic [PW-1:0] mcand;
    logic [W-1:0]  mplier;
    logic [PW-1:0] prod;
    logic [CW-1:0] cnt;

    logic [W:0]    sum_a;
    logic [W:0]    sum_b;
    logic [PW-1:0] prod_next;
    logic          last_step;
    logic          accept;
    logic [PW-2:0] low_neg;

    assign sum_a     = {1'b0, data_in_a} + {1'b0, INC_V};
    assign sum_b     = {1'b0, data_in_b} + {1'b0, INC_V};
    assign prod_next = prod + (mplier[0] ? mcand : {PW{1'b0}});
    assign last_step = (cnt == CW'(1));
    assign accept    = in_valid && (state == IDLE);

`ifdef DATA_PRO_ACC_EN
    logic [PW:0] acc_sum;
    assign acc_sum = {1'b0, data_out} + {1'b0, prod_next};
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = MUL;
            MUL:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == MUL);
        out_valid = (state == DONE);
    end

    // Shift-add engine: the multiplier register is consumed LSB first while the multiplicand walks left.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            mcand    <= '0;
            mplier   <= '0;
            prod     <= '0;
            cnt      <= '0;
            inc_wrap <= 1'b0;
        end else if (accept) begin
            mcand    <= {{W{1'b0}}, sum_a[W-1:0]};
            mplier   <= sum_b[W-1:0];
            prod     <= '0;
            cnt      <= CW'(W);
            inc_wrap <= sum_a[W] | sum_b[W];
        end else if (state == MUL) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            prod   <= prod_next;
            cnt    <= cnt - CW'(1);
        end
    end

    // Result register only moves on the final multiply step (or an accumulator clear while idle).
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            data_out <= '0;
`ifdef DATA_PRO_ACC_EN
            acc_ovf  <= 1'b0;
`endif
        end else begin
`ifdef DATA_PRO_ACC_EN
            if (state == IDLE && acc_clr) begin
                data_out <= '0;
                acc_ovf  <= 1'b0;
            end else if (state == MUL && last_step) begin
                data_out <= acc_sum[PW-1:0];
                acc_ovf  <= acc_ovf | acc_sum[PW];
            end
`else
            if (state == MUL && last_step) begin
                data_out <= prod_next;
            end
`endif
        end
    end

    assign low_neg = ~data_out[PW-2:0] + {{(PW-2){1'b0}}, 1'b1};

    always_comb begin
        data_out_comp = data_out;
        if (data_out[PW-1]) begin
            data_out_comp = {1'b1, low_neg};
        end
    end

endmodule

// File: tb/tb_data_pro_seq.sv
// Self-checking bench for data_pro_seq (W=4, INC=1): directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_data_pro_seq;

    localparam int W   = 4;
    localparam int INC = 1;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] data_in_a = '0;
    logic [3:0] data_in_b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] data_out;
    logic [7:0] data_out_comp;
    logic       busy;
    logic       inc_wrap;
`ifdef DATA_PRO_ACC_EN
    logic       acc_clr = 1'b0;
    logic       acc_ovf;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    data_pro_seq #(.W(W), .INC(INC)) dut (
        .clk           (clk),
        .res           (res),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_in_a     (data_in_a),
        .data_in_b     (data_in_b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_out      (data_out),
        .data_out_comp (data_out_comp),
        .busy          (busy),
        .inc_wrap      (inc_wrap)
`ifdef DATA_PRO_ACC_EN
        ,
        .acc_clr       (acc_clr),
        .acc_ovf       (acc_ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Two's-complement view of a sign-magnitude byte, done with plain arithmetic.
    function automatic logic [7:0] comp_of(input logic [7:0] v);
        int mag;
        if (v < 128) return v;
        mag = int'(v) % 128;
        return 8'(128 + ((128 - mag) % 128));
    endfunction

    // Transaction model: remaining multiply cycles, a pending result flag and the expected registers.
    int         m_rem;
    bit         m_done;
    logic [7:0] m_data;
    bit         m_wrap;
    bit         m_ovf;
    int         m_prod;

    always @(posedge clk or negedge res) begin
        int opa, opb, sum;
        if (!res) begin
            m_rem = 0; m_done = 0; m_data = '0; m_wrap = 0; m_ovf = 0; m_prod = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
`ifdef DATA_PRO_ACC_EN
                sum = int'(m_data) + m_prod;
                if (sum > 255) m_ovf = 1;
                m_data = 8'(sum % 256);
`else
                m_data = 8'(m_prod);
`endif
                m_done = 1;
            end
        end else if (m_done) begin
            if (out_ready) m_done = 0;
        end else begin
`ifdef DATA_PRO_ACC_EN
            if (acc_clr) begin m_data = '0; m_ovf = 0; end
`endif
            if (in_valid) begin
                opa    = (int'(data_in_a) + INC) % (1 << W);
                opb    = (int'(data_in_b) + INC) % (1 << W);
                m_wrap = ((int'(data_in_a) + INC) >= (1 << W)) || ((int'(data_in_b) + INC) >= (1 << W));
                m_prod = opa * opb;
                m_rem  = W;
            end
        end
    end

    always @(negedge clk) begin
        if (res && cmp_en) begin
            check("in_ready",  16'(in_ready),      16'(m_rem == 0 && !m_done));
            check("busy",      16'(busy),          16'(m_rem > 0));
            check("out_valid", 16'(out_valid),     16'(m_done));
            check("data_out",  16'(data_out),      16'(m_data));
            check("comp",      16'(data_out_comp), 16'(comp_of(m_data)));
            check("inc_wrap",  16'(inc_wrap),      16'(m_wrap));
`ifdef DATA_PRO_ACC_EN
            check("acc_ovf",   16'(acc_ovf),       16'(m_ovf));
`endif
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) check("ready_timeout", 16'(in_ready), 16'h1);
    endtask

    // Offer one pair, hold until accepted, then wait (at a falling edge) until the result is presented.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        wait_ready();
        in_valid = 1'b1; data_in_a = a; data_in_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        if (!out_valid) check("valid_timeout", 16'(out_valid), 16'h1);
    endtask

    task automatic clear_acc();
`ifdef DATA_PRO_ACC_EN
        wait_ready();
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
`endif
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp_data, input logic [7:0] exp_comp,
                               input logic exp_wrap);
        check({name, "_data"}, 16'(data_out), 16'(exp_data));
        check({name, "_comp"}, 16'(data_out_comp), 16'(exp_comp));
        check({name, "_wrap"}, 16'(inc_wrap), 16'(exp_wrap));
    endtask

    initial begin
        bit fire;
        #1;
        check("rst_data",  16'(data_out),  16'h0);
        check("rst_valid", 16'(out_valid), 16'h0);
        check("rst_busy",  16'(busy),      16'h0);
        check("rst_ready", 16'(in_ready),  16'h1);
        check("rst_wrap",  16'(inc_wrap),  16'h0);
        @(posedge clk); #1;
        res = 1'b1;
        cmp_en = 1'b1;

        $display("[TB] scenario 1: basic product and latency");
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; data_in_a = 4'd2; data_in_b = 4'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check("latency_valid", 16'(out_valid), 16'(k == 4));
        end
        checkOutput("s1", 8'h0C, 8'h0C, 1'b0);
        @(posedge clk); #1;
        check("s1_ready_back", 16'(in_ready), 16'h1);
        check("s1_valid_drop", 16'(out_valid), 16'h0);

        $display("[TB] scenario 2/4: MSB product then stall");
        clear_acc();
        out_ready = 1'b0;
        applyStimulus(4'd14, 4'd14);
        checkOutput("s2", 8'hE1, 8'h9F, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            in_valid = ~in_valid; data_in_a = 4'd1; data_in_b = 4'd1;
            @(negedge clk);
            check("stall_valid", 16'(out_valid), 16'h1);
            check("stall_data",  16'(data_out),  16'hE1);
            check("stall_ready", 16'(in_ready),  16'h0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release", 16'(out_valid), 16'h0);
        check("stall_retain",  16'(data_out),  16'hE1);

        $display("[TB] scenario 3: operand wrap");
        clear_acc();
        applyStimulus(4'd15, 4'd5);
        checkOutput("s3a", 8'h00, 8'h00, 1'b1);
        clear_acc();
        applyStimulus(4'd0, 4'd0);
        checkOutput("s3b", 8'h01, 8'h01, 1'b0);

        $display("[TB] scenario 5: reset mid-multiply");
        clear_acc();
        wait_ready();
        in_valid = 1'b1; data_in_a = 4'd6; data_in_b = 4'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_busy", 16'(busy), 16'h1);
        res = 1'b0;
        #1;
        check("mid_rst_data",  16'(data_out),  16'h0);
        check("mid_rst_valid", 16'(out_valid), 16'h0);
        check("mid_rst_busy",  16'(busy),      16'h0);
        check("mid_rst_ready", 16'(in_ready),  16'h1);
        @(posedge clk); #1;
        res = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("post_rst_valid", 16'(out_valid), 16'h0);
            check("post_rst_ready", 16'(in_ready),  16'h1);
        end

`ifdef DATA_PRO_ACC_EN
        $display("[TB] scenario 6: accumulate");
        applyStimulus(4'd2, 4'd3);
        check("acc1", 16'(data_out), 16'h0C);
        applyStimulus(4'd14, 4'd14);
        check("acc2", 16'(data_out), 16'hED);
        applyStimulus(4'd2, 4'd3);
        check("acc3", 16'(data_out), 16'hF9);
        applyStimulus(4'd14, 4'd14);
        check("acc4", 16'(data_out), 16'hDA);
        check("acc4_ovf", 16'(acc_ovf), 16'h1);
        clear_acc();
        @(negedge clk);
        check("acc_clr_data", 16'(data_out), 16'h0);
        check("acc_clr_ovf",  16'(acc_ovf),  16'h0);
`endif

        $display("[TB] randomized traffic");
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire || !in_valid) begin
                in_valid  = 1'($urandom_range(0, 1));
                data_in_a = 4'($urandom);
                data_in_b = 4'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
